// File: rtl/wbq_pkg.sv
// Shared types and helpers for the writeback queue: entry layout and
// age-relative-to-head arithmetic used by the bypass search.
package wbq_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // Age 0 is the head (oldest); larger ages are younger entries.
    function automatic int unsigned wbq_age(input int unsigned idx,
                                            input int unsigned rd_ptr,
                                            input int unsigned depth = 4);
        return (idx + depth - rd_ptr) % depth;
    endfunction

endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over the occupied queue entries for one read port.
module wbq_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                    entries [DEPTH],
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
    input  logic [REG_AW-1:0]            addr,
    output logic                         hit,
    output logic [XLEN-1:0]              data
);

    int unsigned age;
    int unsigned best;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        age  = 0;
        best = 0;
        for (int i = 0; i < DEPTH; i++) begin
            age = wbq_age(i, 32'(rd_ptr), DEPTH);
            if (valid[i] && (entries[i].rd == addr) && (!hit || age >= best)) begin
                hit  = 1'b1;
                best = age;
                data = entries[i].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Dual-lane writeback queue feeding the register file's single write port.
// Optional operand bypass from pending entries is built when WBQ_BYPASS_EN is defined.
module wb_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = wbq_pkg::XLEN,
    parameter int AW    = wbq_pkg::REG_AW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in0_valid,
    input  logic [AW-1:0]              in0_rd,
    input  logic [XLEN-1:0]            in0_data,
    input  logic                       in1_valid,
    input  logic [AW-1:0]              in1_rd,
    input  logic [XLEN-1:0]            in1_data,
    output logic                       in_ready,
    input  logic                       drain_hold,
    output logic                       we,
    output logic [AW-1:0]              rw,
    output logic [XLEN-1:0]            inW,
    input  logic [AW-1:0]              ra,
    input  logic [AW-1:0]              rb,
    input  logic [XLEN-1:0]            outA,
    input  logic [XLEN-1:0]            outB,
    output logic [XLEN-1:0]            fwdA,
    output logic [XLEN-1:0]            fwdB,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     slot1;
    logic [CW-1:0]     count_nxt;
    logic [1:0]        n_acc;
    logic              hs0, hs1;
    logic              acc0, acc1;
    logic              pop;
    logic [DEPTH-1:0]  valid;
    wb_entry_t         head;

    assign in_ready = (count <= CW'(DEPTH - 2));
    assign hs0      = in0_valid && in_ready;
    assign hs1      = in1_valid && in_ready;
    // Writes to r0 finish the handshake but never occupy a slot.
    assign acc0     = hs0 && (in0_rd != '0);
    assign acc1     = hs1 && (in1_rd != '0);
    assign n_acc    = {1'b0, acc0} + {1'b0, acc1};
    assign slot1    = acc0 ? (wr_ptr + PW'(1)) : wr_ptr;

    assign pop       = we;
    assign count_nxt = count + CW'(n_acc) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_acc);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (acc0) mem[wr_ptr] <= '{rd: in0_rd, data: in0_data};
        if (acc1) mem[slot1]  <= '{rd: in1_rd, data: in1_data};
    end

    assign head = mem[rd_ptr];
    assign we   = (count != '0) && !drain_hold;
    assign rw   = (count != '0) ? head.rd   : '0;
    assign inW  = (count != '0) ? head.data : '0;

    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = wbq_age(i, 32'(rd_ptr), DEPTH) < 32'(count);
        end
    end

`ifdef WBQ_BYPASS_EN
    logic            hit_a, hit_b;
    logic [XLEN-1:0] data_a, data_b;

    wbq_match #(.DEPTH(DEPTH)) u_match_a (
        .entries (mem),
        .valid   (valid),
        .rd_ptr  (rd_ptr),
        .addr    (ra),
        .hit     (hit_a),
        .data    (data_a)
    );

    wbq_match #(.DEPTH(DEPTH)) u_match_b (
        .entries (mem),
        .valid   (valid),
        .rd_ptr  (rd_ptr),
        .addr    (rb),
        .hit     (hit_b),
        .data    (data_b)
    );

    assign fwdA = (ra == '0) ? '0 : (hit_a ? data_a : outA);
    assign fwdB = (rb == '0) ? '0 : (hit_b ? data_b : outB);
`else
    // Without bypass the pipeline must stall reads on pending destinations.
    logic unused_valid;
    assign unused_valid = ^valid;
    assign fwdA = (ra == '0) ? '0 : outA;
    assign fwdB = (rb == '0) ? '0 : outB;
`endif

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        ((hs0 || hs1) |-> in_ready) and (count_nxt <= CW'(DEPTH)));

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue with a behavioural register file.
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in0_valid, in1_valid;
    logic [AW-1:0]   in0_rd, in1_rd;
    logic [XLEN-1:0] in0_data, in1_data;
    logic            in_ready;
    logic            drain_hold;
    logic            we;
    logic [AW-1:0]   rw;
    logic [XLEN-1:0] inW;
    logic [AW-1:0]   ra, rb;
    logic [XLEN-1:0] outA, outB;
    logic [XLEN-1:0] fwdA, fwdB;
    logic [2:0]      count;

    logic [XLEN-1:0] rf [32];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) rf[rw] <= inW;
    end

    assign outA = rf[ra];
    assign outB = rf[rb];

    wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_valid  (in0_valid),
        .in0_rd     (in0_rd),
        .in0_data   (in0_data),
        .in1_valid  (in1_valid),
        .in1_rd     (in1_rd),
        .in1_data   (in1_data),
        .in_ready   (in_ready),
        .drain_hold (drain_hold),
        .we         (we),
        .rw         (rw),
        .inW        (inW),
        .ra         (ra),
        .rb         (rb),
        .outA       (outA),
        .outB       (outB),
        .fwdA       (fwdA),
        .fwdB       (fwdB),
        .count      (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_rd    = '0;
        in1_rd    = '0;
        in0_data  = '0;
        in1_data  = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[0]  = 32'hDEAD;
        rf[12] = 32'h1234;

        rst_n      = 1'b0;
        drain_hold = 1'b0;
        ra         = '0;
        rb         = '0;
        clear_lanes();
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_rw", 32'(rw), 0);
        chk("rst_inW", inW, 0);
        chk("rst_fwdA_r0", fwdA, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // single write and forward
        in0_valid = 1'b1; in0_rd = 5'd10; in0_data = 32'd2; ra = 5'd10;
        #1;
        chk("s1_fwdA_incoming", fwdA, 0);
        tick();
        clear_lanes();
        #1;
        chk("s1_count", 32'(count), 1);
        chk("s1_we", 32'(we), 1);
        chk("s1_rw", 32'(rw), 10);
        chk("s1_inW", inW, 2);
        chk("s1_fwdA_pending", fwdA, BYP ? 32'd2 : 32'd0);
        tick();
        chk("s1_count_after", 32'(count), 0);
        chk("s1_we_after", 32'(we), 0);
        chk("s1_fwdA_after", fwdA, 2);

        // dual lane same destination under hold
        drain_hold = 1'b1;
        in0_valid = 1'b1; in0_rd = 5'd11; in0_data = 32'd4;
        in1_valid = 1'b1; in1_rd = 5'd11; in1_data = 32'd16;
        rb = 5'd11;
        tick();
        clear_lanes();
        #1;
        chk("s2_count", 32'(count), 2);
        chk("s2_we_hold", 32'(we), 0);
        chk("s2_fwdB", fwdB, BYP ? 32'd16 : 32'd0);
        drain_hold = 1'b0;
        #1;
        chk("s2_we", 32'(we), 1);
        chk("s2_inW_first", inW, 4);
        tick();
        chk("s2_count_mid", 32'(count), 1);
        chk("s2_inW_second", inW, 16);
        chk("s2_fwdB_mid", fwdB, BYP ? 32'd16 : 32'd4);
        tick();
        chk("s2_count_end", 32'(count), 0);
        chk("s2_outB", outB, 16);
        chk("s2_fwdB_end", fwdB, 16);

        // register 0 dropped
        in0_valid = 1'b1; in0_rd = 5'd0; in0_data = 32'hFF; ra = 5'd0;
        tick();
        clear_lanes();
        #1;
        chk("s3_count", 32'(count), 0);
        chk("s3_we", 32'(we), 0);
        chk("s3_fwdA_r0", fwdA, 0);

        // fill, back-pressure, wrap, order
        drain_hold = 1'b1;
        in0_valid = 1'b1; in0_rd = 5'd1; in0_data = 32'h101;
        in1_valid = 1'b1; in1_rd = 5'd2; in1_data = 32'h102;
        tick();
        in0_rd = 5'd3; in0_data = 32'h103;
        in1_rd = 5'd4; in1_data = 32'h104;
        #1;
        chk("s4_ready_half", 32'(in_ready), 1);
        tick();
        clear_lanes();
        #1;
        chk("s4_count_full", 32'(count), 4);
        chk("s4_ready_full", 32'(in_ready), 0);
        in0_valid = 1'b1; in0_rd = 5'd7; in0_data = 32'h77;
        tick();
        clear_lanes();
        chk("s4_count_blocked", 32'(count), 4);
        drain_hold = 1'b0;
        #1;
        chk("s4_we", 32'(we), 1);
        chk("s4_rw1", 32'(rw), 1);
        chk("s4_inW1", inW, 32'h101);
        tick();
        chk("s4_count3", 32'(count), 3);
        chk("s4_rw2", 32'(rw), 2);
        chk("s4_ready3", 32'(in_ready), 0);
        tick();
        chk("s4_count2", 32'(count), 2);
        chk("s4_rw3", 32'(rw), 3);
        chk("s4_ready2", 32'(in_ready), 1);
        in0_valid = 1'b1; in0_rd = 5'd9; in0_data = 32'h99;
        tick();
        clear_lanes();
        chk("s4_count_pushpop", 32'(count), 2);
        chk("s4_rw4", 32'(rw), 4);
        tick();
        chk("s4_count1", 32'(count), 1);
        chk("s4_rw9", 32'(rw), 9);
        chk("s4_inW9", inW, 32'h99);
        tick();
        chk("s4_count0", 32'(count), 0);
        chk("s4_we_idle", 32'(we), 0);
        chk("s4_rf4", rf[4], 32'h104);
        chk("s4_rf9", rf[9], 32'h99);

        // reset mid-operation
        drain_hold = 1'b1;
        in0_valid = 1'b1; in0_rd = 5'd12; in0_data = 32'hC1;
        in1_valid = 1'b1; in1_rd = 5'd13; in1_data = 32'hC2;
        tick();
        in1_valid = 1'b0;
        in0_rd = 5'd12; in0_data = 32'hC3;
        tick();
        clear_lanes();
        ra = 5'd12;
        #1;
        chk("s5_count", 32'(count), 3);
        chk("s5_fwdA_pending", fwdA, BYP ? 32'hC3 : 32'h1234);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_count", 32'(count), 0);
        chk("s5_rst_we", 32'(we), 0);
        chk("s5_rst_rw", 32'(rw), 0);
        chk("s5_rst_inW", inW, 0);
        chk("s5_rst_ready", 32'(in_ready), 1);
        chk("s5_rst_fwdA", fwdA, 32'h1234);
        drain_hold = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s5_no_we", 32'(we), 0);
        end
        chk("s5_rf12", rf[12], 32'h1234);

        // pending value vs stale register file
        drain_hold = 1'b1;
        in0_valid = 1'b1; in0_rd = 5'd5; in0_data = 32'd7; ra = 5'd5;
        tick();
        clear_lanes();
        #1;
        chk("s6_outA_stale", outA, 0);
        chk("s6_fwdA", fwdA, BYP ? 32'd7 : 32'd0);
        drain_hold = 1'b0;
        #1;
        chk("s6_we", 32'(we), 1);
        tick();
        chk("s6_fwdA_after", fwdA, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue that is the writing end of the register file's single write port. It accepts up to two retiring results per cycle from the dual-issue pipelines and buffers them in order. It drains one entry per cycle into the register file's `we`/`rw`/`inW` port. While entries are pending, it forwards the youngest matching value onto both read ports, so operand reads never see stale data.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; must be a power of two and at least 2.
- `XLEN`, default 32: data width.
- `AW`, default 5: register address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in0_valid`  in  1  lane-0 writeback present; lane 0 is the older lane.
- `in0_rd`  in  AW  lane-0 destination register.
- `in0_data`  in  XLEN  lane-0 result.
- `in1_valid`  in  1  lane-1 writeback present; lane 1 is the younger lane.
- `in1_rd`  in  AW  lane-1 destination register.
- `in1_data`  in  XLEN  lane-1 result.
- `in_ready`  out  1  high when at least 2 slots are free; covers both lanes.
- `drain_hold`  in  1  blocks draining this cycle.
- `we`  out  1  register file write enable.
- `rw`  out  AW  register file write address.
- `inW`  out  XLEN  register file write data.
- `ra`  in  AW  read address A; same signal as the register file's `ra`.
- `rb`  in  AW  read address B; same signal as the register file's `rb`.
- `outA`  in  XLEN  register file read data A.
- `outB`  in  XLEN  register file read data B.
- `fwdA`  out  XLEN  corrected operand A.
- `fwdB`  out  XLEN  corrected operand B.
- `count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- **Circular buffer.** Read and write pointers of width $clog2(DEPTH) wrap modulo DEPTH. `count` is tracked separately, which distinguishes full from empty.
- **Enqueue.** A lane is accepted at an edge when `inX_valid && in_ready`.
  - If both lanes are accepted, lane 0 takes slot `wr_ptr` and lane 1 takes `wr_ptr+1`.
  - If only lane 1 is valid, it takes `wr_ptr`.
- **Register 0.** An accepted lane with `rd == 0` completes its handshake but is not stored and does not advance `wr_ptr`.
- **Ready.** `in_ready` equals `(DEPTH - count) >= 2`. It is computed from the current `count` only; a same-cycle pop is not credited.
- **Drain.**
  - `we` equals `(count != 0) && !drain_hold`.
  - `rw` and `inW` are the head entry, driven combinationally.
  - When `we` is high, the register file writes at the edge and the head pops at that same edge.
- **Simultaneous events.** Enqueue and pop in the same cycle are both performed; `count` changes by (accepted non-zero lanes) minus pop.
- **Bypass lookup.**
  - For `ra`, search every occupied entry, including the head being written this cycle.
  - The youngest entry with matching `rd` wins and drives `fwdA`.
  - With no match, `fwdA = outA`. If `ra == 0`, `fwdA = 0`.
  - Port B follows the same rule with `rb`, `outB` and `fwdB`.
- **Not bypassed.** Incoming lanes that are not yet enqueued are not forwarded.
- **Duplicate destinations.** Entries drain in order, so the register file ends with the youngest value.
- **Overflow.** Impossible by construction. An assertion flags any accepted handshake when `in_ready` is low.

## Timing
- **Reset values.** Asserting `rst_n` low immediately gives `count = 0`, pointers 0, `we = 0`, `rw = 0`, `inW = 0` and `in_ready = 1`.
  - `fwdA = outA` and `fwdB = outB`, except 0 for address 0.
  - Reset mid-operation discards all pending entries; those writes are lost.
- **Write latency.** An entry accepted at edge N can drive `we` in cycle N+1 and is written to the register file at edge N+1, unless `drain_hold` is high or older entries are queued.
- **Forwarding latency.** Combinational, 0 cycles, from the cycle after acceptance until the pop edge.
  - From the pop edge onward, the register file supplies the value.
- **Throughput.**
  - Sustained drain is 1 entry per cycle.
  - With two lanes per cycle the queue fills; `in_ready` falls when `count > DEPTH-2`.

## Configuration
- **Macro:** `WBQ_BYPASS_EN`.
- **Defined:** full bypass lookup as described in Operation.
- **Undefined:**
  - No match logic is built; `fwdA = outA` and `fwdB = outB`, still forced to 0 for address 0.
  - The pipeline must then stall reads on pending destinations.
  - Queue, drain and handshake behaviour are unchanged.

## Structure
- **Package `wbq_pkg`.**
  - Constants: `XLEN`, `REG_AW`.
  - `typedef struct packed { logic [REG_AW-1:0] rd; logic [XLEN-1:0] data; } wb_entry_t`.
  - Function `wbq_age(idx, rd_ptr)`, which returns an entry's age relative to the head.
- **Sub-module `wbq_match`.**
  - Inputs: the entry array, valid mask, `rd_ptr` and a lookup address.
  - Outputs: hit and youngest-match data.
  - Instantiated twice, for ports A and B, only under `WBQ_BYPASS_EN`.

## Test plan
- **Reset and single write.** After reset, check `count = 0`, `we = 0`, `in_ready = 1`. Drive lane 0 with rd = 10 and data = 2 for one cycle. Next cycle: `we = 1`, `rw = 10`, `inW = 2`. With `ra = 10`, `fwdA = 2` both before and after the pop.
- **Dual lane with hold.** Hold `drain_hold = 1`. Drive lane 0 (rd = 11, data = 4) and lane 1 (rd = 11, data = 16) together. Check `count = 2` and `fwdB` for `rb = 11` equals 16. Release the hold: drains write 4 then 16, and the register file's `outB` ends at 16.
- **Register 0 drop.** Lane 0 with rd = 0 and data = 0xFF is accepted but `count` does not change and `we` stays 0. `ra = 0` gives `fwdA = 0`.
- **Fill and back-pressure.** With `DEPTH = 4` and `drain_hold = 1`, enqueue 2 pairs. Check `in_ready = 0` and `count = 4`. Release the hold: `in_ready` returns after 2 pops. Pointers wrap, and the FIFO order 1, 2, 3, 4 is preserved in `rw`.
- **Reset mid-operation.** With 3 entries pending, pulse `rst_n` low. Outputs go to reset values at once and no `we` pulse follows. `fwdA` shows the register file's old value.
- **Macro undefined.** Queue entry rd = 5 with data = 7, then `ra = 5`. `fwdA` equals `outA` (stale) until the drain.
